// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a length-prefixed big-endian byte stream,
// packs it into 32-bit words written to consecutive addresses from 0, and holds
// the core in reset for the duration of the load.
module instr_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrite, StDone, StErr
    } state_e;

    state_e state_q, state_d;

    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  error_q, error_d;

    logic                  xfer;
    logic                  start;
    logic [15:0]           len_full;
    logic                  len_bad;
    logic [ADDR_WIDTH:0]   word_cnt_inc;
    logic                  last_word;

    assign xfer         = byte_valid_i & byte_ready_o;
    assign start        = load_start_i & ((state_q == StIdle) | (state_q == StErr));
    assign len_full     = {len_q[15:8], byte_data_i};
    assign len_bad      = (len_full == 16'd0) | (32'(len_full) > Depth);
    // Counter is one bit wider than the address so a full-depth load can reach N.
    assign word_cnt_inc = word_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_word    = (32'(word_cnt_inc) == 32'(len_q));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load_start_i) state_d = StLenHi;
            StLenHi: if (xfer) state_d = StLenLo;
            StLenLo: if (xfer) state_d = len_bad ? StErr : StData;
            StData:  if (xfer && byte_cnt_q == 2'd3) state_d = StWrite;
            StWrite: state_d = last_word ? StDone : StData;
            StDone:  state_d = StIdle;
            StErr:   if (load_start_i) state_d = StLenHi;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        byte_ready_o = 1'b0;
        imem_we_o    = 1'b0;
        cpu_hold_o   = 1'b1;
        done_o       = 1'b0;
        unique case (state_q)
            StIdle:                   cpu_hold_o = 1'b0;
            StLenHi, StLenLo, StData: byte_ready_o = 1'b1;
            StWrite:                  imem_we_o = 1'b1;
            StDone: begin
                cpu_hold_o = 1'b0;
                done_o     = 1'b1;
            end
            StErr:                    cpu_hold_o = 1'b1;
            default:                  cpu_hold_o = 1'b0;
        endcase
    end

    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign error_o      = error_q;

    // Datapath next-state: length capture, byte packing, word counting
    always_comb begin
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        error_d    = error_q;
        if (start) begin
            word_cnt_d = '0;
            byte_cnt_d = 2'd0;
            error_d    = 1'b0;
        end
        if (xfer && state_q == StLenHi) begin
            len_d[15:8] = byte_data_i;
        end
        if (xfer && state_q == StLenLo) begin
            len_d[7:0] = byte_data_i;
            error_d    = len_bad;
        end
        if (xfer && state_q == StData) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = {asm_q[15:0], byte_data_i};
            // Output registers only update on the word boundary so they hold
            // their values outside the write cycle.
            if (byte_cnt_q == 2'd3) begin
                wdata_d = {asm_q, byte_data_i};
                addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            end
        end
        if (state_q == StWrite) begin
            word_cnt_d = word_cnt_inc;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            error_q    <= error_d;
        end
    end

endmodule
